// File: rtl/id_decode_stage_if.sv
// Decode-to-execute stage bus: IF/ID-side request, EX-side hold/flush, and the EX pipeline registers.
// The decode stage uses the slave modport; upstream/downstream logic uses the master modport.
interface id_decode_stage_if #(
  parameter int unsigned ALUC_W = 4,
  parameter int unsigned CNT_W  = 16
);
  logic [31:0]       instr_i;
  logic              id_valid_i;
  logic              ex_ready_i;
  logic              flush_i;
  logic              ex_valid;
  logic              reg_write_e;
  logic              mem_write_e;
  logic              jump_e;
  logic              branch_e;
  logic              alu_src_e;
  logic [1:0]        result_src_e;
  logic [2:0]        imm_src_e;
  logic [ALUC_W-1:0] alu_control_e;
  logic [4:0]        rd_e;
  logic [4:0]        rs1_e;
  logic [4:0]        rs2_e;
  logic [2:0]        funct3_e;
  logic              id_stall;
  logic              illegal_e;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output instr_i, id_valid_i, ex_ready_i, flush_i,
    input  ex_valid, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
           result_src_e, imm_src_e, alu_control_e, rd_e, rs1_e, rs2_e, funct3_e,
           id_stall, illegal_e, stall_cnt
  );

  modport slave (
    input  instr_i, id_valid_i, ex_ready_i, flush_i,
    output ex_valid, reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
           result_src_e, imm_src_e, alu_control_e, rd_e, rs1_e, rs2_e, funct3_e,
           id_stall, illegal_e, stall_cnt
  );
endinterface

// File: rtl/id_decode_stage.sv
// RV32I decode stage with ID/EX pipeline registers, load-use stall detection and a saturating bubble counter.
// Define ID_ILLEGAL_EN to flag unknown opcodes and malformed R-type funct7 through illegal_e.
module id_decode_stage #(
  parameter int unsigned ALUC_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input logic             clk,
  input logic             rst,
  id_decode_stage_if.slave bus
);

  localparam int unsigned ACW = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [ACW-1:0] ALU_ADD  = 4'd0;
  localparam logic [ACW-1:0] ALU_SUB  = 4'd1;
  localparam logic [ACW-1:0] ALU_AND  = 4'd2;
  localparam logic [ACW-1:0] ALU_OR   = 4'd3;
  localparam logic [ACW-1:0] ALU_SLT  = 4'd4;
  localparam logic [ACW-1:0] ALU_XOR  = 4'd5;
  localparam logic [ACW-1:0] ALU_SLL  = 4'd6;
  localparam logic [ACW-1:0] ALU_SRL  = 4'd7;
  localparam logic [ACW-1:0] ALU_SRA  = 4'd8;
  localparam logic [ACW-1:0] ALU_SLTU = 4'd9;

`ifdef ID_ILLEGAL_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  typedef struct packed {
    logic           reg_write;
    logic           mem_write;
    logic           jump;
    logic           branch;
    logic           alu_src;
    logic [1:0]     result_src;
    logic [2:0]     imm_src;
    logic [ACW-1:0] alu_control;
    logic           illegal;
  } ctrl_t;

  typedef struct packed {
    ctrl_t      ctrl;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
  } ex_t;

  function automatic logic [ACW-1:0] alu_arith(input logic [2:0] f3, input logic f7_5,
                                               input logic is_r);
    case (f3)
      3'b000:  alu_arith = (is_r && f7_5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_arith = ALU_SLL;
      3'b010:  alu_arith = ALU_SLT;
      3'b011:  alu_arith = ALU_SLTU;
      3'b100:  alu_arith = ALU_XOR;
      3'b101:  alu_arith = f7_5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_arith = ALU_OR;
      default: alu_arith = ALU_AND;
    endcase
  endfunction

  // Branch comparisons: eq/ne and the reserved pair subtract, lt/ge signed, ltu/geu unsigned.
  function automatic logic [ACW-1:0] alu_branch(input logic [2:0] f3);
    case (f3[2:1])
      2'b10:   alu_branch = ALU_SLT;
      2'b11:   alu_branch = ALU_SLTU;
      default: alu_branch = ALU_SUB;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       f7_5;
  logic       r_legal;
  ctrl_t      dec;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       stall_c;
  ex_t        cap;
  ex_t        ex_q;
  logic       ex_valid_q;
  logic [CNT_W-1:0] cnt_q;

  assign opcode = bus.instr_i[6:0];
  assign funct3 = bus.instr_i[14:12];
  assign f7_5   = bus.instr_i[30];

`ifdef ID_ILLEGAL_EN
  assign r_legal = (bus.instr_i[31:25] == 7'b0000000) || (bus.instr_i[31:25] == 7'b0100000);
`else
  assign r_legal = 1'b1;
`endif

  // Main decoder; unknown opcodes fall through to bubble controls.
  always_comb begin
    dec      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_R: begin
        if (r_legal) begin
          dec.reg_write   = 1'b1;
          dec.alu_control = alu_arith(funct3, f7_5, 1'b1);
          uses_rs1        = 1'b1;
          uses_rs2        = 1'b1;
        end else begin
          dec.illegal = ILL_EN;
        end
      end
      OP_I: begin
        dec.reg_write   = 1'b1;
        dec.alu_src     = 1'b1;
        dec.alu_control = alu_arith(funct3, f7_5, 1'b0);
        uses_rs1        = 1'b1;
      end
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b01;
        dec.alu_src    = 1'b1;
        uses_rs1       = 1'b1;
      end
      OP_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'b001;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OP_BRANCH: begin
        dec.branch      = 1'b1;
        dec.imm_src     = 3'b010;
        dec.alu_control = alu_branch(funct3);
        uses_rs1        = 1'b1;
        uses_rs2        = 1'b1;
      end
      OP_JAL: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = 3'b011;
      end
      OP_JALR: begin
        dec.jump       = 1'b1;
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        uses_rs1       = 1'b1;
      end
      OP_LUI: begin
        dec.reg_write  = 1'b1;
        dec.result_src = 2'b11;
        dec.imm_src    = 3'b100;
      end
      default: dec.illegal = ILL_EN;
    endcase
  end

  // Load in EX whose destination feeds a source this instruction actually reads.
  assign stall_c = bus.id_valid_i && ex_valid_q && (ex_q.ctrl.result_src == 2'b01) &&
                   (ex_q.rd != 5'd0) &&
                   ((uses_rs1 && (bus.instr_i[19:15] == ex_q.rd)) ||
                    (uses_rs2 && (bus.instr_i[24:20] == ex_q.rd)));

  assign cap = bus.id_valid_i ?
               ex_t'{ctrl: dec, rd: bus.instr_i[11:7], rs1: bus.instr_i[19:15],
                     rs2: bus.instr_i[24:20], funct3: funct3} : '0;

  // Priority: reset, flush, hold, load-use bubble, capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
      cnt_q      <= '0;
    end else if (bus.flush_i) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (bus.ex_ready_i) begin
      if (stall_c) begin
        ex_valid_q <= 1'b0;
        ex_q       <= '0;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end else begin
        ex_valid_q <= bus.id_valid_i;
        ex_q       <= cap;
      end
    end
  end

  assign bus.ex_valid      = ex_valid_q;
  assign bus.reg_write_e   = ex_q.ctrl.reg_write;
  assign bus.mem_write_e   = ex_q.ctrl.mem_write;
  assign bus.jump_e        = ex_q.ctrl.jump;
  assign bus.branch_e      = ex_q.ctrl.branch;
  assign bus.alu_src_e     = ex_q.ctrl.alu_src;
  assign bus.result_src_e  = ex_q.ctrl.result_src;
  assign bus.imm_src_e     = ex_q.ctrl.imm_src;
  assign bus.alu_control_e = ALUC_W'(ex_q.ctrl.alu_control);
  assign bus.rd_e          = ex_q.rd;
  assign bus.rs1_e         = ex_q.rs1;
  assign bus.rs2_e         = ex_q.rs2;
  assign bus.funct3_e      = ex_q.funct3;
  assign bus.illegal_e     = ex_q.ctrl.illegal;
  assign bus.id_stall      = stall_c;
  assign bus.stall_cnt     = cnt_q;

endmodule
